// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port unified RAM between instruction fetch and load/store.
// Data has fixed priority, and a starvation counter forces a fetch grant after MAX_WAIT denials.
// Define RAM_ARB_RR_EN to use alternating round-robin on conflicts instead.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [31:0]           o_if_rdata,

    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [31:0]           i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [31:0]           o_d_rdata,

    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_wdata,
    input  logic [31:0]           i_ram_rdata
);

    // One-hot owner of the response due in the next cycle.
    typedef enum logic [1:0] {
        RSEL_NONE  = 2'b00,
        RSEL_FETCH = 2'b01,
        RSEL_DATA  = 2'b10
    } rsel_t;

    rsel_t rsel;
    rsel_t rsel_next;
    logic  fetch_wins;

`ifdef RAM_ARB_RR_EN
    logic last_d;

    assign fetch_wins = last_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_d <= 1'b0;
        end else if (o_d_gnt) begin
            last_d <= 1'b1;
        end else if (o_if_gnt) begin
            last_d <= 1'b0;
        end
    end
`else
    localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    assign fetch_wins = (wait_cnt == MAX_WAIT_CNT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
        end else if (o_if_gnt) begin
            wait_cnt <= '0;
        end else if (i_if_req && (wait_cnt != MAX_WAIT_CNT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    // Grants are suppressed while reset is asserted so no write can slip through.
    always_comb begin
        o_if_gnt = 1'b0;
        o_d_gnt  = 1'b0;
        if (i_rst_n) begin
            if (i_if_req && i_d_req) begin
                o_if_gnt = fetch_wins;
                o_d_gnt  = ~fetch_wins;
            end else begin
                o_if_gnt = i_if_req;
                o_d_gnt  = i_d_req;
            end
        end
    end

    assign o_ram_addr  = o_d_gnt ? i_d_addr : i_if_addr;
    assign o_ram_wdata = i_d_wdata;
    assign o_ram_we    = o_d_gnt & i_d_we;

    always_comb begin
        rsel_next = RSEL_NONE;
        if (o_if_gnt) begin
            rsel_next = RSEL_FETCH;
        end else if (o_d_gnt && !i_d_we) begin
            rsel_next = RSEL_DATA;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsel       <= RSEL_NONE;
            o_if_rdata <= '0;
            o_d_rdata  <= '0;
        end else begin
            rsel <= rsel_next;
            if (rsel_next == RSEL_FETCH) begin
                o_if_rdata <= i_ram_rdata;
            end
            if (rsel_next == RSEL_DATA) begin
                o_d_rdata <= i_ram_rdata;
            end
        end
    end

    assign o_if_rvalid = (rsel == RSEL_FETCH);
    assign o_d_rvalid  = (rsel == RSEL_DATA);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM model.
module tb_ram_arbiter;

    localparam int unsigned AW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [31:0]   o_if_rdata;
    logic          i_d_req;
    logic          i_d_we;
    logic [AW-1:0] i_d_addr;
    logic [31:0]   i_d_wdata;
    logic          o_d_gnt;
    logic          o_d_rvalid;
    logic [31:0]   o_d_rdata;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_addr;
    logic [31:0]   o_ram_wdata;
    logic [31:0]   i_ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    always #5 i_clk = ~i_clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata)
    );

    // Word-addressed RAM: low two byte-address bits ignored, combinational read.
    always @(posedge i_clk) begin
        if (o_ram_we) mem[o_ram_addr[7:2]] <= o_ram_wdata;
    end
    assign i_ram_rdata = mem[o_ram_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge i_clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;

        // Reset with both requests and a store pending.
        i_rst_n   = 1'b0;
        i_if_req  = 1'b1;
        i_if_addr = 32'h10;
        i_d_req   = 1'b1;
        i_d_we    = 1'b1;
        i_d_addr  = 32'h10;
        i_d_wdata = 32'hBAD0BAD0;
        next_cycle();
        next_cycle();
        mid_cycle();
        check("rst_if_gnt", {31'b0, o_if_gnt}, 32'd0);
        check("rst_d_gnt", {31'b0, o_d_gnt}, 32'd0);
        check("rst_ram_we", {31'b0, o_ram_we}, 32'd0);
        check("rst_if_rvalid", {31'b0, o_if_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'b0, o_d_rvalid}, 32'd0);
        check("rst_if_rdata", o_if_rdata, 32'd0);
        check("rst_d_rdata", o_d_rdata, 32'd0);

        // Lone fetch of word 4.
        next_cycle();
        i_rst_n  = 1'b1;
        i_d_req  = 1'b0;
        i_d_we   = 1'b0;
        mid_cycle();
        check("rst_mem_unchanged", mem[4], 32'hDEADBEEF);
        check("fetch_gnt", {31'b0, o_if_gnt}, 32'd1);
        check("fetch_ram_addr", o_ram_addr, 32'h10);
        check("fetch_ram_we", {31'b0, o_ram_we}, 32'd0);
        next_cycle();
        i_if_req = 1'b0;
        mid_cycle();
        check("fetch_rvalid", {31'b0, o_if_rvalid}, 32'd1);
        check("fetch_rdata", o_if_rdata, 32'hDEADBEEF);

        // Store then load to 0x20.
        next_cycle();
        i_d_req   = 1'b1;
        i_d_we    = 1'b1;
        i_d_addr  = 32'h20;
        i_d_wdata = 32'h12345678;
        mid_cycle();
        check("store_gnt", {31'b0, o_d_gnt}, 32'd1);
        check("store_ram_we", {31'b0, o_ram_we}, 32'd1);
        check("store_ram_addr", o_ram_addr, 32'h20);
        next_cycle();
        i_d_we = 1'b0;
        mid_cycle();
        check("store_no_rvalid", {31'b0, o_d_rvalid}, 32'd0);
        check("load_gnt", {31'b0, o_d_gnt}, 32'd1);
        check("load_ram_we", {31'b0, o_ram_we}, 32'd0);
        next_cycle();
        i_d_req   = 1'b0;
        i_if_req  = 1'b1;
        i_if_addr = 32'h20;
        mid_cycle();
        check("load_rvalid", {31'b0, o_d_rvalid}, 32'd1);
        check("load_rdata", o_d_rdata, 32'h12345678);
        check("fetch2_gnt", {31'b0, o_if_gnt}, 32'd1);
        next_cycle();
        i_if_addr = 32'h10;
        i_d_req   = 1'b1;
        i_d_we    = 1'b0;
        i_d_addr  = 32'h20;
        mid_cycle();
        check("fetch2_rdata", o_if_rdata, 32'h12345678);

        // Continuous conflict; the previous winner was fetch.
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
`ifdef RAM_ARB_RR_EN
            exp_f = (i % 2) == 1;
`else
            exp_f = (i % 5) == 4;
            check($sformatf("conf_wait_cnt_%0d", i), {24'b0, dut.wait_cnt}, 32'(i % 5));
`endif
            check($sformatf("conf_if_gnt_%0d", i), {31'b0, o_if_gnt}, {31'b0, exp_f});
            check($sformatf("conf_d_gnt_%0d", i), {31'b0, o_d_gnt}, {31'b0, ~exp_f});
            check($sformatf("conf_addr_%0d", i), o_ram_addr, exp_f ? 32'h10 : 32'h20);
            next_cycle();
            mid_cycle();
        end

        // Load granted in N, reset asserted in N+1.
        next_cycle();
        i_if_req = 1'b0;
        i_d_req  = 1'b1;
        i_d_we   = 1'b0;
        i_d_addr = 32'h10;
        mid_cycle();
        check("rmid_load_gnt", {31'b0, o_d_gnt}, 32'd1);
        next_cycle();
        i_rst_n   = 1'b0;
        i_d_we    = 1'b1;
        i_d_wdata = 32'hFFFFFFFF;
        mid_cycle();
        check("rmid_rvalid_n1", {31'b0, o_d_rvalid}, 32'd1);
        check("rmid_rdata_n1", o_d_rdata, 32'hDEADBEEF);
        check("rmid_d_gnt_n1", {31'b0, o_d_gnt}, 32'd0);
        check("rmid_ram_we_n1", {31'b0, o_ram_we}, 32'd0);
        next_cycle();
        i_rst_n = 1'b1;
        i_d_req = 1'b0;
        i_d_we  = 1'b0;
        mid_cycle();
        check("rmid_rvalid_n2", {31'b0, o_d_rvalid}, 32'd0);
        check("rmid_rdata_n2", o_d_rdata, 32'd0);
        check("rmid_if_rdata_n2", o_if_rdata, 32'd0);
        check("rmid_mem_unchanged", mem[4], 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
